// File: rtl/credbasedfc_pkg.sv
// Shared widths for the credit-based link: default sizes, buffer depth, and pointer/count types.
// The sender's credit counter uses the same cnt_t, so both ends agree on 0..DEPTH.
package credbasedfc_pkg;
  localparam int D_WIDTH = 6;
  localparam int A_WIDTH = 2;
  localparam int DEPTH   = 2**A_WIDTH;

  typedef logic [A_WIDTH-1:0] ptr_t;
  typedef logic [A_WIDTH:0]   cnt_t;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/credbasedfc_rx_if.sv
// Upstream beat/credit and downstream valid/ready signals of the credit-based receiver.
// The master side is the environment (sender plus consumer). The slave side is the receiver.
interface credbasedfc_rx_if #(
  parameter int D_WIDTH = credbasedfc_pkg::D_WIDTH,
  parameter int A_WIDTH = credbasedfc_pkg::A_WIDTH
);
  logic [D_WIDTH-1:0] up_data;
  logic               up_valid;
  logic               up_credit;
  logic [D_WIDTH-1:0] down_data;
  logic               down_valid;
  logic               down_ready;
  logic [A_WIDTH:0]   occupancy;
  logic               overflow_err;

  modport master (
    output up_data, up_valid, down_ready,
    input  up_credit, down_data, down_valid, occupancy, overflow_err
  );

  modport slave (
    input  up_data, up_valid, down_ready,
    output up_credit, down_data, down_valid, occupancy, overflow_err
  );
endinterface

// File: rtl/credbasedfc_rx_mem.sv
// Flop-array beat storage with a registered write port and an asynchronous read port.
// Read data follows rd_addr in the same cycle. The contents are never reset.
module credbasedfc_rx_mem #(
  parameter int D_WIDTH = credbasedfc_pkg::D_WIDTH,
  parameter int A_WIDTH = credbasedfc_pkg::A_WIDTH
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [A_WIDTH-1:0] wr_addr,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic [D_WIDTH-1:0] rd_data
);
  import credbasedfc_pkg::*;

  logic [D_WIDTH-1:0] mem [depth_of(A_WIDTH)];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/credbasedfc_rx.sv
// Credit-based receiver: buffers unthrottled upstream beats and drains them with valid/ready.
// A beat is readable 1 cycle after its push. Each pop returns one credit pulse 1 cycle later.
module credbasedfc_rx #(
  parameter int D_WIDTH = credbasedfc_pkg::D_WIDTH,
  parameter int A_WIDTH = credbasedfc_pkg::A_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  credbasedfc_rx_if.slave  bus
);
  import credbasedfc_pkg::*;

  localparam int DEPTH_L = depth_of(A_WIDTH);

  logic [A_WIDTH-1:0] wr_ptr;
  logic [A_WIDTH-1:0] rd_ptr;
  logic [A_WIDTH:0]   count;
  logic               credit_q;
  logic               err_q;
  logic               push;
  logic               pop;
  logic               full;
  logic               wr_en;
  logic [D_WIDTH-1:0] rd_data;

  assign push  = bus.up_valid;
  assign pop   = (count != '0) && bus.down_ready;
  assign full  = (count == (A_WIDTH+1)'(DEPTH_L));
  // When full, a simultaneous pop frees the slot, so the push still lands.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      credit_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      credit_q <= pop;
      if (push && full && !pop) err_q <= 1'b1;
    end
  end

  credbasedfc_rx_mem #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH)) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (bus.up_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  assign bus.down_data    = rd_data;
  assign bus.down_valid   = (count != '0);
  assign bus.occupancy    = count;
  assign bus.up_credit    = credit_q;
  assign bus.overflow_err = err_q;
endmodule

// File: tb/tb_credbasedfc_rx.sv
// Bench for credbasedfc_rx: directed scenarios plus a credit-respecting random stream.
// The stream is checked against a queue-based model of the receive buffer.
module tb_credbasedfc_rx;
  import credbasedfc_pkg::*;

  localparam int DW    = 6;
  localparam int AW    = 2;
  localparam int DEPTH_T = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  credbasedfc_rx_if #(.D_WIDTH(DW), .A_WIDTH(AW)) bus ();
  credbasedfc_rx #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_mis = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] popped[$];
  bit            m_cred;
  bit            m_err;

  // Model one clock edge from the current inputs, then move to just after that edge.
  task automatic advance();
    bit p;
    bit f;
    if (rst) begin
      mq.delete();
      m_cred = 1'b0;
      m_err  = 1'b0;
    end else begin
      f = (mq.size() == DEPTH_T);
      p = (mq.size() != 0) && (bus.down_ready === 1'b1);
      if (p) popped.push_back(mq.pop_front());
      if (bus.up_valid === 1'b1) begin
        if (!f || p) mq.push_back(bus.up_data);
        else m_err = 1'b1;
      end
      m_cred = p;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.up_valid = 1'b0; bus.up_data = '0; bus.down_ready = 1'b0;
    advance(); advance();
    n_vec++; if (bus.down_valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid got %b want 0", bus.down_valid); end
    n_vec++; if (bus.up_credit !== 1'b0) begin n_mis++; $display("FAIL reset_credit got %b want 0", bus.up_credit); end
    n_vec++; if (bus.occupancy !== 3'd0) begin n_mis++; $display("FAIL reset_occ got %0d want 0", bus.occupancy); end
    n_vec++; if (bus.overflow_err !== 1'b0) begin n_mis++; $display("FAIL reset_err got %b want 0", bus.overflow_err); end
    rst = 1'b0;
    advance();
  endtask

  task automatic test_basic();
    bus.down_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.up_valid = 1'b1; bus.up_data = DW'(i + 1);
      advance();
      n_vec++;
      if (bus.down_valid !== 1'b1 || bus.down_data !== DW'(i + 1) || bus.up_credit !== (i > 0)) begin
        n_mis++;
        $display("FAIL basic_beat[%0d] got v=%b d=%h c=%b want v=1 d=%h c=%b",
                 i, bus.down_valid, bus.down_data, bus.up_credit, DW'(i + 1), (i > 0));
      end
    end
    bus.up_valid = 1'b0;
    advance();
    n_vec++;
    if (bus.down_valid !== 1'b0 || bus.up_credit !== 1'b1 || bus.occupancy !== 3'd0) begin
      n_mis++;
      $display("FAIL basic_tail got v=%b c=%b occ=%0d want v=0 c=1 occ=0", bus.down_valid, bus.up_credit, bus.occupancy);
    end
    advance();
    n_vec++; if (bus.up_credit !== 1'b0) begin n_mis++; $display("FAIL basic_credit_end got %b want 0", bus.up_credit); end
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] d[4];
    bus.down_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d[i] = DW'($urandom);
      bus.up_valid = 1'b1; bus.up_data = d[i];
      advance();
      n_vec++;
      if (bus.occupancy !== 3'(i + 1) || bus.up_credit !== 1'b0) begin
        n_mis++;
        $display("FAIL fill_occ[%0d] got occ=%0d c=%b want occ=%0d c=0", i, bus.occupancy, bus.up_credit, i + 1);
      end
    end
    bus.up_valid = 1'b0; bus.down_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (bus.down_valid !== 1'b1 || bus.down_data !== d[i] || bus.up_credit !== (i > 0)) begin
        n_mis++;
        $display("FAIL drain_beat[%0d] got v=%b d=%h c=%b want v=1 d=%h c=%b",
                 i, bus.down_valid, bus.down_data, bus.up_credit, d[i], (i > 0));
      end
      advance();
    end
    n_vec++;
    if (bus.occupancy !== 3'd0 || bus.up_credit !== 1'b1 || bus.down_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL drain_end got occ=%0d c=%b v=%b want occ=0 c=1 v=0", bus.occupancy, bus.up_credit, bus.down_valid);
    end
    advance();
  endtask

  task automatic test_simul_full();
    logic [DW-1:0] seq[4];
    seq[0] = 6'h11; seq[1] = 6'h12; seq[2] = 6'h13; seq[3] = 6'h2A;
    bus.down_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.up_valid = 1'b1; bus.up_data = DW'(8'h10 + i);
      advance();
    end
    bus.up_data = 6'h2A; bus.down_ready = 1'b1;
    advance();
    n_vec++;
    if (bus.occupancy !== 3'd4 || bus.overflow_err !== 1'b0 || bus.up_credit !== 1'b1) begin
      n_mis++;
      $display("FAIL simul_full got occ=%0d err=%b c=%b want occ=4 err=0 c=1", bus.occupancy, bus.overflow_err, bus.up_credit);
    end
    bus.up_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (bus.down_data !== seq[i]) begin
        n_mis++;
        $display("FAIL simul_order[%0d] got %h want %h", i, bus.down_data, seq[i]);
      end
      advance();
    end
    advance();
  endtask

  task automatic test_overflow();
    logic [DW-1:0] d[4];
    bus.down_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d[i] = DW'($urandom);
      bus.up_valid = 1'b1; bus.up_data = d[i];
      advance();
    end
    bus.up_data = 6'h3F;
    advance();
    bus.up_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (bus.overflow_err !== 1'b1 || bus.occupancy !== 3'd4) begin
        n_mis++;
        $display("FAIL ovf_hold[%0d] got err=%b occ=%0d want err=1 occ=4", i, bus.overflow_err, bus.occupancy);
      end
      advance();
    end
    bus.down_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (bus.down_data !== d[i]) begin
        n_mis++;
        $display("FAIL ovf_drain[%0d] got %h want %h", i, bus.down_data, d[i]);
      end
      advance();
    end
    n_vec++;
    if (bus.occupancy !== 3'd0 || bus.overflow_err !== 1'b1) begin
      n_mis++;
      $display("FAIL ovf_sticky got occ=%0d err=%b want occ=0 err=1", bus.occupancy, bus.overflow_err);
    end
    rst = 1'b1;
    advance();
    n_vec++; if (bus.overflow_err !== 1'b0) begin n_mis++; $display("FAIL ovf_clear got %b want 0", bus.overflow_err); end
    rst = 1'b0;
    advance();
  endtask

  task automatic test_wrap();
    int s_cred = DEPTH_T;
    int sent = 0;
    int ncred = 0;
    int cyc = 0;
    popped.delete();
    bus.up_valid = 1'b0;
    while (popped.size() < 20 && cyc < 400) begin
      n_vec++;
      if (bus.occupancy !== 3'(mq.size()) || bus.down_valid !== (mq.size() != 0) ||
          bus.up_credit !== m_cred || bus.overflow_err !== 1'b0) begin
        n_mis++;
        $display("FAIL wrap_state[%0d] got occ=%0d v=%b c=%b err=%b want occ=%0d v=%b c=%b err=0",
                 cyc, bus.occupancy, bus.down_valid, bus.up_credit, bus.overflow_err,
                 mq.size(), (mq.size() != 0), m_cred);
      end
      if (mq.size() != 0) begin
        n_vec++;
        if (bus.down_data !== mq[0]) begin
          n_mis++;
          $display("FAIL wrap_head[%0d] got %h want %h", cyc, bus.down_data, mq[0]);
        end
      end
      n_vec++;
      if (s_cred + mq.size() + int'(m_cred) != DEPTH_T ||
          s_cred + int'(bus.occupancy) + int'(bus.up_credit) != DEPTH_T) begin
        n_mis++;
        $display("FAIL wrap_invariant[%0d] got cred=%0d occ=%0d pend=%b want sum=%0d",
                 cyc, s_cred, bus.occupancy, bus.up_credit, DEPTH_T);
      end
      if (bus.up_credit === 1'b1) begin s_cred++; ncred++; end
      if (s_cred > 0 && sent < 20) begin
        bus.up_valid = 1'b1; bus.up_data = DW'(sent);
        sent++; s_cred--;
      end else begin
        bus.up_valid = 1'b0;
      end
      bus.down_ready = 1'($urandom_range(0, 1));
      advance();
      cyc++;
    end
    bus.up_valid = 1'b0;
    if (bus.up_credit === 1'b1) ncred++;
    n_vec++;
    if (popped.size() != 20) begin
      n_mis++;
      $display("FAIL wrap_timeout got %0d beats want 20", popped.size());
    end
    for (int i = 0; i < popped.size(); i++) begin
      n_vec++;
      if (popped[i] !== DW'(i)) begin
        n_mis++;
        $display("FAIL wrap_order[%0d] got %h want %h", i, popped[i], DW'(i));
      end
    end
    n_vec++;
    if (ncred != 20) begin n_mis++; $display("FAIL wrap_credits got %0d want 20", ncred); end
    advance();
  endtask

  task automatic test_reset_mid();
    bus.down_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.up_valid = 1'b1; bus.up_data = DW'($urandom);
      advance();
    end
    bus.up_data = DW'($urandom); bus.down_ready = 1'b1;
    advance();
    n_vec++;
    if (bus.occupancy !== 3'd3 || bus.up_credit !== 1'b1) begin
      n_mis++;
      $display("FAIL rstmid_pre got occ=%0d c=%b want occ=3 c=1", bus.occupancy, bus.up_credit);
    end
    bus.up_valid = 1'b0; bus.down_ready = 1'b0;
    #2 rst = 1'b1;
    mq.delete(); m_cred = 1'b0; m_err = 1'b0;
    #1;
    n_vec++;
    if ({bus.down_valid, bus.up_credit, bus.occupancy, bus.overflow_err} !== 6'd0) begin
      n_mis++;
      $display("FAIL rstmid_async got v=%b c=%b occ=%0d err=%b want all 0",
               bus.down_valid, bus.up_credit, bus.occupancy, bus.overflow_err);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({bus.down_valid, bus.up_credit, bus.occupancy, bus.overflow_err} !== 6'd0) begin
      n_mis++;
      $display("FAIL rstmid_held got v=%b c=%b occ=%0d err=%b want all 0",
               bus.down_valid, bus.up_credit, bus.occupancy, bus.overflow_err);
    end
    rst = 1'b0;
    advance();
    n_vec++;
    if ({bus.down_valid, bus.up_credit, bus.occupancy, bus.overflow_err} !== 6'd0) begin
      n_mis++;
      $display("FAIL rstmid_after got v=%b c=%b occ=%0d err=%b want all 0",
               bus.down_valid, bus.up_credit, bus.occupancy, bus.overflow_err);
    end
  endtask

  initial begin
    bus.up_valid = 1'b0;
    bus.up_data = '0;
    bus.down_ready = 1'b0;
    m_cred = 1'b0;
    m_err = 1'b0;
    test_reset();
    test_basic();
    test_fill_drain();
    test_simul_full();
    test_overflow();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
